// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory and the CPU decoder.
// The NOP encoding here is the same word the decoder treats as a no-op.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } state_t;

  localparam logic [15:0] NOP_WORD = 16'hE200;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Fetch port and program-load stream between the CPU/host side and the instruction memory.
// The master drives the fetch request and load beats; the slave is the memory.
interface inst_mem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 32
);

  logic              fetch_en;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              pc_err;

  logic              ld_start;
  logic [PC_W-1:0]   ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              busy;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output fetch_en, pc, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  instr, instr_valid, pc_err, ld_ready, busy, ld_count
  );

  modport slave (
    input  fetch_en, pc, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output instr, instr_valid, pc_err, ld_ready, busy, ld_count
  );

endinterface

// File: rtl/inst_mem_ram.sv
// DEPTH x DATA_W memory, one write port and one registered write-first read port.
// Read data holds when re is low; only the read register is reset, never the array.
module inst_mem_ram #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 10,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-cycle write to the read index forwards the new data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= RST_VAL;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with a 1-cycle registered fetch port and a valid/ready load stream.
// After reset a clear sequencer writes NOP to every word; fetch and load wait for it.
module inst_mem_loader #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 10,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(inst_mem_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset_n,
  inst_mem_loader_if.slave  bus
);

  import inst_mem_pkg::*;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   ld_count;
  logic              instr_valid;
  logic              pc_err;
  logic              ld_ready;
  logic              busy;

  logic              fetch_go;
  logic              accept;
  logic              pc_oob;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              unused_ld_base;

  assign fetch_go = bus.fetch_en && (state != ST_CLEAR);
  assign accept   = bus.ld_valid && ld_ready;
  assign pc_oob   = (bus.pc >> ADDR_W) != '0;

  assign we    = (state == ST_CLEAR) || accept;
  assign waddr = (state == ST_CLEAR) ? clr_ptr  : wr_ptr;
  assign wdata = (state == ST_CLEAR) ? NOP_WORD : bus.ld_data;

  assign unused_ld_base = ^bus.ld_base[PC_W-1:ADDR_W];

  inst_mem_ram #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RST_VAL (NOP_WORD)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (fetch_go),
    .raddr   (bus.pc[ADDR_W-1:0]),
    .rdata   (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_CLEAR;
      clr_ptr     <= '0;
      wr_ptr      <= '0;
      ld_count    <= '0;
      instr_valid <= 1'b0;
      pc_err      <= 1'b0;
      ld_ready    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      // pc_err travels with the read register, so it holds exactly when instr holds.
      instr_valid <= fetch_go;
      if (fetch_go) pc_err <= pc_oob;

      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.ld_start) begin
            state    <= ST_LOAD;
            wr_ptr   <= bus.ld_base[ADDR_W-1:0];
            ld_count <= '0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
            if (bus.ld_last) begin
              state    <= ST_IDLE;
              ld_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_CLEAR;
          clr_ptr  <= '0;
          ld_ready <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  // Out-of-range fetches present NOP rather than the aliased word.
  assign bus.instr       = pc_err ? NOP_WORD : rdata;
  assign bus.instr_valid = instr_valid;
  assign bus.pc_err      = pc_err;
  assign bus.ld_ready    = ld_ready;
  assign bus.busy        = busy;
  assign bus.ld_count    = ld_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a 16-word memory.
module tb_inst_mem_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int PC_W   = 32;
  localparam logic [15:0] NOP = 16'hE200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

  inst_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] p, input logic [15:0] exp, input logic exp_err, input string tag);
    bus.fetch_en = 1'b1;
    bus.pc       = p;
    tick();
    bus.fetch_en = 1'b0;
    chk({tag, "_instr"}, 32'(bus.instr), 32'(exp));
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_err"},   32'(bus.pc_err), 32'(exp_err));
  endtask

  task automatic start_load(input logic [31:0] base);
    bus.ld_base  = base;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("start_ready", 32'(bus.ld_ready), 32'd1);
    chk("start_busy",  32'(bus.busy),     32'd1);
    chk("start_count", 32'(bus.ld_count), 32'd0);
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Counts cycles until busy drops; the NOP fill of 16 words takes 16 cycles.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
      chk({tag, "_blocked"}, 32'(bus.instr_valid), 32'd0);
    end
    chk({tag, "_cycles"}, 32'(n), 32'd16);
  endtask

  initial begin
    int acc;
    int cyc;

    bus.fetch_en = 1'b0;
    bus.pc       = '0;
    bus.ld_start = 1'b0;
    bus.ld_base  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",  32'(bus.busy),        32'd1);
    chk("rst_instr", 32'(bus.instr),       32'(NOP));
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_err",   32'(bus.pc_err),      32'd0);
    chk("rst_ready", 32'(bus.ld_ready),    32'd0);
    chk("rst_count", 32'(bus.ld_count),    32'd0);

    // Clear sequence with fetch and ld_start asserted; both must be ignored
    reset_n      = 1'b1;
    bus.fetch_en = 1'b1;
    bus.ld_start = 1'b1;
    bus.ld_base  = 32'd5;
    wait_clear("clear1");
    bus.fetch_en = 1'b0;
    bus.ld_start = 1'b0;
    chk("clear1_ready", 32'(bus.ld_ready), 32'd0);
    for (int p = 0; p < 16; p++) fetch(32'(p), NOP, 1'b0, "nopfill");

    // Three-beat burst at base 3
    start_load(32'd3);
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    beat(16'h3333, 1'b1);
    chk("b1_count", 32'(bus.ld_count), 32'd3);
    chk("b1_busy",  32'(bus.busy),     32'd0);
    chk("b1_ready", 32'(bus.ld_ready), 32'd0);
    fetch(32'd3, 16'h1111, 1'b0, "b1_pc3");
    fetch(32'd4, 16'h2222, 1'b0, "b1_pc4");
    fetch(32'd5, 16'h3333, 1'b0, "b1_pc5");

    // Wrapping burst at 14; ld_valid toggles and idle cycles carry junk with ld_last=1
    start_load(32'd14);
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 20) begin
      if (cyc % 2 == 0) begin
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hA000 + 16'(acc);
        bus.ld_last  = (acc == 3);
      end else begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 16'hDEAD;
        bus.ld_last  = 1'b1;
      end
      tick();
      if (bus.ld_valid) acc++;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk("b2_cycles", 32'(cyc), 32'd7);
    chk("b2_count",  32'(bus.ld_count), 32'd4);
    chk("b2_busy",   32'(bus.busy),     32'd0);
    fetch(32'd14, 16'hA000, 1'b0, "b2_pc14");
    fetch(32'd15, 16'hA001, 1'b0, "b2_pc15");
    fetch(32'd0,  16'hA002, 1'b0, "b2_pc0");
    fetch(32'd1,  16'hA003, 1'b0, "b2_pc1");
    fetch(32'd2,  NOP,      1'b0, "b2_pc2");
    fetch(32'd13, NOP,      1'b0, "b2_pc13");

    // Write-first forwarding, then out-of-range fetch during LOAD
    start_load(32'd7);
    bus.fetch_en = 1'b1;
    bus.pc       = 32'd7;
    beat(16'hABCD, 1'b0);
    bus.fetch_en = 1'b0;
    chk("wf_instr", 32'(bus.instr),       32'hABCD);
    chk("wf_valid", 32'(bus.instr_valid), 32'd1);
    fetch(32'h0001_0000, NOP, 1'b1, "oob");
    beat(16'h5555, 1'b1);
    chk("b3_count", 32'(bus.ld_count), 32'd2);
    chk("b3_busy",  32'(bus.busy),     32'd0);
    fetch(32'd8, 16'h5555, 1'b0, "b3_pc8");
    fetch(32'd7, 16'hABCD, 1'b0, "b3_pc7");

    // Stall holds instr while pc moves
    fetch(32'd3, 16'h1111, 1'b0, "st_pre");
    bus.pc = 32'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_instr", 32'(bus.instr),       32'h1111);
      chk("st_valid", 32'(bus.instr_valid), 32'd0);
    end
    fetch(32'd4, 16'h2222, 1'b0, "st_post");

    // Reset mid-LOAD after the second beat
    start_load(32'd9);
    beat(16'h7777, 1'b0);
    beat(16'h8888, 1'b0);
    chk("ab_count_pre", 32'(bus.ld_count), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("ab_busy",  32'(bus.busy),        32'd1);
    chk("ab_ready", 32'(bus.ld_ready),    32'd0);
    chk("ab_count", 32'(bus.ld_count),    32'd0);
    chk("ab_instr", 32'(bus.instr),       32'(NOP));
    chk("ab_valid", 32'(bus.instr_valid), 32'd0);
    #1;
    reset_n = 1'b1;
    wait_clear("clear2");
    fetch(32'd9,  NOP, 1'b0, "ab_pc9");
    fetch(32'd10, NOP, 1'b0, "ab_pc10");
    fetch(32'd3,  NOP, 1'b0, "ab_pc3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
